// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int MD_W     = 32;
   localparam int MD_ITERS = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      ZERO = 2'd3
   } md_state_t;

   // 0x80000000 maps to 2^31, which still fits as an unsigned 32-bit magnitude.
   function automatic logic [MD_W-1:0] md_mag(input logic [MD_W-1:0] v, input logic sgn);
      return (sgn && v[MD_W-1]) ? (~v + {{(MD_W-1){1'b0}}, 1'b1}) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 64-bit working register: shift-add or restoring shift-subtract.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int W = MD_W
) (
   input  logic           div_mode,
   input  logic [2*W-1:0] acc_in,
   input  logic [W-1:0]   opnd,
   output logic [2*W-1:0] acc_out
);

   logic [W:0] sum;
   logic [W:0] rem;
   logic [W:0] diff;

   always_comb begin
      sum     = {1'b0, acc_in[2*W-1:W]} + (acc_in[0] ? {1'b0, opnd} : {(W+1){1'b0}});
      // Shifted partial remainder needs W+1 bits before the compare.
      rem     = acc_in[2*W-1:W-1];
      diff    = rem - {1'b0, opnd};
      acc_out = {sum, acc_in[W-1:1]};
      if (div_mode) begin
         if (rem >= {1'b0, opnd}) begin
            acc_out = {diff[W-1:0], acc_in[W-2:0], 1'b1};
         end else begin
            acc_out = {acc_in[2*W-2:W-1], acc_in[W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; hi/lo only move on completion or MTHI/MTLO.
module alu_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       state_dbg
);

   localparam logic [4:0] LAST_ITER = 5'(MD_ITERS - 1);

   // Handshake: start is taken only in IDLE (busy=0); done pulses one cycle as busy drops.
   md_state_t          state;
   logic [4:0]         cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   opnd;
   logic               is_div;
   logic               neg_res;
   logic               neg_rem;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign state_dbg = state;
   assign mag_a     = md_mag(a, op[0]);
   assign mag_b     = md_mag(b, op[0]);
   assign prod_fix  = neg_res ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
   assign quo_fix   = neg_res ? (~acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc[WIDTH-1:0];
   assign rem_fix   = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                              : acc[2*WIDTH-1:WIDTH];

   muldiv_step #(.W(WIDTH)) u_step (
      .div_mode (is_div),
      .acc_in   (acc),
      .opnd     (opnd),
      .acc_out  (acc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  is_div   <= op[1];
                  neg_res  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem  <= op[0] & a[WIDTH-1];
                  div_zero <= 1'b0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  // Multiplier sits in the low half and shifts out; dividend shifts up into the high half.
                  acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                  opnd     <= op[1] ? mag_b : mag_a;
                  state    <= (op[1] && b == '0) ? ZERO : CALC;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            CALC: begin
               acc <= acc_next;
               cnt <= cnt + 5'd1;
               if (cnt == LAST_ITER) state <= SIGN;
            end
            SIGN: begin
               if (is_div) begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            ZERO: begin
               div_zero <= 1'b1;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Iterative 32-bit multiply/divide unit holding the HI/LO register pair for the multi-cycle CPU. Sits directly upstream of the ALU result selector: `hi` and `lo` drive two of its 32-bit data inputs (I6/I7), alongside the single-cycle ALU results. It accepts MULT/MULTU/DIV/DIVU with a start/busy/done handshake and also supports direct HI/LO writes (MTHI/MTLO).

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is required.
- `clk  in  1`  rising-edge clock.
- `rst_n  in  1`  asynchronous, active-low reset.
- `start  in  1`  request an operation; sampled only in IDLE.
- `op  in  2`  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a  in  32`  multiplicand or dividend.
- `b  in  32`  multiplier or divisor.
- `hi_we  in  1`  write `wdata` to HI (MTHI).
- `lo_we  in  1`  write `wdata` to LO (MTLO).
- `wdata  in  32`  data for direct HI/LO writes.
- `busy  out  1`  operation in progress.
- `done  out  1`  one-cycle pulse when an operation completes.
- `div_zero  out  1`  set with `done` when a DIV/DIVU had b==0; held until the next accepted start.
- `hi  out  32`  HI register.
- `lo  out  32`  LO register.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state IDLE, iteration counter 0.
- **IDLE**
  - `start`=1 latches the absolute values of `a`/`b`, the result sign flags and `op`; clears `div_zero`; goes to CALC.
  - Signed ops take the two's-complement magnitude; 0x80000000 gives magnitude 2^31, held unsigned.
  - If `op` is a divide and `b`==0: go to ZERO instead of CALC.
- **CALC**
  - 32 iterations, one per cycle, counter 0..31.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; quotient and remainder build in a 64-bit register.
  - After iteration 31, go to SIGN.
- **SIGN**
  - Multiply: negate the 64-bit product if the signs differed, then {hi,lo} = product.
  - Divide: lo = quotient, hi = remainder. Quotient is negated if the signs differed (truncation toward zero). Remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
  - Pulse `done`, return to IDLE.
- **ZERO**
  - hi/lo unchanged; `div_zero`=1; pulse `done`; return to IDLE.
- **Direct writes**
  - `hi_we`/`lo_we` apply in IDLE only; ignored in any other state.
  - If `start` and a write occur in the same IDLE cycle, `start` wins and the write is dropped.
- `start` outside IDLE is ignored: no queueing, no error.
- `busy` = 1 in CALC, SIGN and ZERO.
- `hi`/`lo` change only in SIGN or on a direct write. They hold their old values for the whole operation, so the downstream selector never sees partial results.

## Timing
- Edge E0 samples `start`; `busy` is high after E0.
- Normal operation:
  - Edges E1..E32 perform the 32 iterations.
  - E33 (SIGN) updates hi/lo, sets `done`=1 and `busy`=0.
  - Results are visible in the cycle after E33, so latency is 33 cycles from the start edge.
- Divide-by-zero: E1 (ZERO) sets `done`=1 and `div_zero`=1, `busy`=0. Latency is 1 cycle.
- `done` is high for exactly one cycle.
- A new `start` may be asserted in the same cycle `done` is high; it is accepted at the next edge, giving back-to-back operation.
- Direct write: hi/lo update at the edge where `hi_we`/`lo_we` is sampled in IDLE.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). No `done` is produced for the aborted operation.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`;
  - state enum IDLE / CALC / SIGN / ZERO;
  - `MD_ITERS`=32.
- One sub-module, `muldiv_step`: a purely combinational single radix-2 iteration, with a mode input selecting shift-add or shift-subtract on the 64-bit working register.
- The top level holds the FSM, counter, operand and sign registers, the sign fix-up, and hi/lo.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → at E33 hi=0xFFFFFFFE, lo=0x00000001; `done` pulses once; `busy` high for E0..E32.
- MULT a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload with `hi_we`/`lo_we` (wdata=0x1234 for both), then DIVU a=100 b=0 → `done` and `div_zero` at E1; hi=lo=0x1234 unchanged.
- Robustness sequence:
  - Start MULTU 3×5.
  - Pulse `start` (DIVU 9/3) and `lo_we` at iteration 10: both ignored; result hi=0, lo=15.
  - Start MULTU 6×7, then drive `rst_n` low at iteration 10: all outputs go to 0 immediately and no `done` appears.
  - After reset, MULTU 6×7 → lo=42.
